ui_state_ctrl: RTL and testbench

UI_STATE_CTRL -- requirements
Module: ui_state_ctrl

---
 rtl/ui_state_ctrl_pkg.sv | 24 ++
 rtl/ui_state_ctrl_btn.sv | 68 ++++++
 rtl/ui_state_ctrl.sv | 151 +++++++++++++++
 tb/tb_ui_state_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_state_ctrl_pkg.sv
// Shared encodings for the UI state controller: main-state codes,
// error codes and the limits used by the confirm/back handling.
package ui_state_ctrl_pkg;

    localparam logic [2:0] ST_MENU     = 3'd0;
    localparam logic [2:0] ST_INPUT    = 3'd1;
    localparam logic [2:0] ST_GENERATE = 3'd2;
    localparam logic [2:0] ST_DISPLAY  = 3'd3;
    localparam logic [2:0] ST_COMPUTE  = 3'd4;
    localparam logic [2:0] ST_SETTING  = 3'd5;

    localparam logic [3:0] ERR_NONE = 4'd0;
    localparam logic [3:0] ERR_MODE = 4'd1;
    localparam logic [3:0] ERR_OP   = 4'd2;

    localparam logic [3:0] OP_MAX  = 4'd9;
    localparam logic [3:0] SUB_MAX = 4'd15;

    // A mode request is usable only if it names one of the five work modes.
    function automatic logic mode_valid(input logic [2:0] mode);
        return (mode >= ST_INPUT) && (mode <= ST_SETTING);
    endfunction

endpackage

// File: rtl/ui_state_ctrl_btn.sv
// Button conditioner: 2-flop synchroniser, counting debouncer and a
// one-cycle press pulse on each accepted rising level. A button that is
// already held when reset releases never produces a press until it has
// been seen released.
module btn_debounce #(
    parameter logic [19:0] DB_LIMIT = 20'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    logic       sync_a;
    logic       sync_b;
    logic [1:0] prime;
    logic       armed;
    logic [19:0] cnt;
    logic       settle;

    assign settle = (cnt == DB_LIMIT - 20'd1);

    // Synchronise the raw input; prime marks when sync_b holds a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prime  <= 2'b00;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            prime  <= {prime[0], 1'b1};
        end
    end

    // Arm press generation once the button has been seen released after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (prime[1] && !sync_b) begin
            armed <= 1'b1;
        end
    end

    // Accept a new level after DB_LIMIT consecutive differing samples; any bounce restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= 20'd0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b != level) begin
                if (settle) begin
                    level <= sync_b;
                    cnt   <= 20'd0;
                    press <= sync_b & armed;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else begin
                cnt <= 20'd0;
            end
        end
    end

endmodule

// File: rtl/ui_state_ctrl.sv
// UI state controller: debounced confirm/back buttons drive the mode FSM,
// a prescaler produces the error_timer tick, and error codes age out
// after 64 ticks unless cleared by back.
module ui_state_ctrl
    import ui_state_ctrl_pkg::*;
#(
    parameter logic [19:0] DB_LIMIT = 20'd1000000,
    parameter logic [23:0] TICK_DIV = 24'd3125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_confirm_raw,
    input  logic       btn_back_raw,
    input  logic [2:0] sw_mode,
    input  logic [3:0] sw_op,
    input  logic       err_req,
    input  logic [3:0] err_code_in,
    output logic [2:0] main_state,
    output logic [3:0] sub_state,
    output logic [3:0] op_type,
    output logic [3:0] error_code,
    output logic [5:0] error_timer
);

    logic        unused_confirm_level;
    logic        unused_back_level;
    logic        confirm_press;
    logic        back_press;
    logic [23:0] presc;
    logic        tick;
    logic [5:0]  age;
    logic        ext_err;
    logic        confirm_ok;
    logic        age_expire;
    logic [2:0]  main_next;
    logic [3:0]  sub_next;
    logic [3:0]  op_next;
    logic [3:0]  int_err;
    logic [3:0]  err_next;
    logic        err_set;

    btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_confirm (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_confirm_raw),
        .level (unused_confirm_level),
        .press (confirm_press)
    );

    btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_back (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_back_raw),
        .level (unused_back_level),
        .press (back_press)
    );

    assign tick       = (presc == TICK_DIV - 24'd1);
    assign ext_err    = err_req && (err_code_in != ERR_NONE);
    assign confirm_ok = confirm_press && !back_press && (error_code == ERR_NONE);
    assign age_expire = tick && (age == 6'd63) && (error_code != ERR_NONE);

    // Free-running prescaler and tick counter; only reset stops them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= 24'd0;
            error_timer <= 6'd0;
        end else if (tick) begin
            presc       <= 24'd0;
            error_timer <= error_timer + 6'd1;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    // Next-state decode for the mode FSM and the error code.
    always_comb begin
        main_next = main_state;
        sub_next  = sub_state;
        op_next   = op_type;
        int_err   = ERR_NONE;
        if (back_press) begin
            main_next = ST_MENU;
            sub_next  = 4'd0;
        end else if (confirm_ok) begin
            case (main_state)
                ST_MENU: begin
                    if (mode_valid(sw_mode)) begin
                        main_next = sw_mode;
                        sub_next  = 4'd0;
                    end else begin
                        int_err = ERR_MODE;
                    end
                end
                ST_COMPUTE: begin
                    if (sub_state == 4'd0) begin
                        if (sw_op <= OP_MAX) begin
                            op_next  = sw_op;
                            sub_next = 4'd1;
                        end else begin
                            int_err = ERR_OP;
                        end
                    end else if (sub_state != SUB_MAX) begin
                        sub_next = sub_state + 4'd1;
                    end
                end
                default: begin
                    if (sub_state != SUB_MAX) begin
                        sub_next = sub_state + 4'd1;
                    end
                end
            endcase
        end

        err_next = error_code;
        err_set  = 1'b0;
        if (ext_err) begin
            err_next = err_code_in;
            err_set  = 1'b1;
        end else if (back_press) begin
            err_next = ERR_NONE;
        end else if (int_err != ERR_NONE) begin
            err_next = int_err;
            err_set  = 1'b1;
        end else if (age_expire) begin
            err_next = ERR_NONE;
        end
    end

    // State, operation and error registers; the age counter restarts on every error set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_state <= ST_MENU;
            sub_state  <= 4'd0;
            op_type    <= 4'd0;
            error_code <= ERR_NONE;
            age        <= 6'd0;
        end else begin
            main_state <= main_next;
            sub_state  <= sub_next;
            op_type    <= op_next;
            error_code <= err_next;
            if (err_set) begin
                age <= 6'd0;
            end else if (tick) begin
                age <= age + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_ui_state_ctrl.sv
// Self-checking bench for ui_state_ctrl with DB_LIMIT=4, TICK_DIV=8.
// A behavioural model tracks the design cycle by cycle from the rules:
// a button is accepted after 4 equal synchronised samples, ticks fall on
// every 8th cycle, and errors expire 64 ticks after being set.
module tb_ui_state_ctrl;

    localparam int DBI = 4;
    localparam int TDI = 8;
    localparam int LOGN = 8192;

    logic       clk;
    logic       rst_n;
    logic       btn_confirm_raw;
    logic       btn_back_raw;
    logic [2:0] sw_mode;
    logic [3:0] sw_op;
    logic       err_req;
    logic [3:0] err_code_in;
    logic [2:0] main_state;
    logic [3:0] sub_state;
    logic [3:0] op_type;
    logic [3:0] error_code;
    logic [5:0] error_timer;

    ui_state_ctrl #(.DB_LIMIT(20'd4), .TICK_DIV(24'd8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_confirm_raw (btn_confirm_raw),
        .btn_back_raw    (btn_back_raw),
        .sw_mode         (sw_mode),
        .sw_op           (sw_op),
        .err_req         (err_req),
        .err_code_in     (err_code_in),
        .main_state      (main_state),
        .sub_state       (sub_state),
        .op_type         (op_type),
        .error_code      (error_code),
        .error_timer     (error_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         m_cyc;
    int         m_ticks;
    int         m_expire;
    int         m_set_cyc;
    logic [2:0] m_main;
    logic [3:0] m_sub;
    logic [3:0] m_op;
    logic [3:0] m_err;
    bit         raw_log  [2][LOGN];
    bit         seen_log [2][LOGN];
    bit         m_lvl    [2];
    bit         m_armed  [2];
    bit         m_pend   [2];

    task automatic model_reset();
        m_cyc = 0; m_ticks = 0; m_expire = 0; m_set_cyc = 0;
        m_main = 3'd0; m_sub = 4'd0; m_op = 4'd0; m_err = 4'd0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 0; m_armed[b] = 0; m_pend[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit tick, cp, bp, ext, set, all_diff, seen, rawv, newp;
        logic [3:0] internal;
        m_cyc++;
        tick = (m_cyc % TDI == 0);
        if (tick) m_ticks++;
        cp = m_pend[0];
        bp = m_pend[1];
        ext = err_req && (err_code_in != 4'd0);
        internal = 4'd0;
        set = 0;
        if (bp) begin
            m_main = 3'd0;
            m_sub  = 4'd0;
        end else if (cp && m_err == 4'd0) begin
            if (m_main == 3'd0) begin
                if (sw_mode >= 3'd1 && sw_mode <= 3'd5) begin
                    m_main = sw_mode;
                    m_sub  = 4'd0;
                end else internal = 4'd1;
            end else if (m_main == 3'd4 && m_sub == 4'd0) begin
                if (sw_op <= 4'd9) begin
                    m_op  = sw_op;
                    m_sub = 4'd1;
                end else internal = 4'd2;
            end else if (m_sub != 4'd15) begin
                m_sub = m_sub + 4'd1;
            end
        end
        if (ext) begin
            m_err = err_code_in; set = 1;
        end else if (bp) begin
            m_err = 4'd0;
        end else if (internal != 4'd0) begin
            m_err = internal; set = 1;
        end else if (m_err != 4'd0 && tick && m_ticks == m_expire) begin
            m_err = 4'd0;
        end
        if (set) begin
            m_expire  = m_ticks + 64;
            m_set_cyc = m_cyc;
        end
        for (int b = 0; b < 2; b++) begin
            rawv = (b == 0) ? btn_confirm_raw : btn_back_raw;
            seen = (m_cyc >= 3) ? raw_log[b][(m_cyc - 2) % LOGN] : 1'b0;
            raw_log[b][m_cyc % LOGN]  = rawv;
            seen_log[b][m_cyc % LOGN] = seen;
            if (m_cyc >= 3 && !seen) m_armed[b] = 1;
            newp = 0;
            if (m_cyc >= DBI) begin
                all_diff = 1;
                for (int j = 0; j < DBI; j++)
                    if (seen_log[b][(m_cyc - j) % LOGN] == m_lvl[b]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[b] = ~m_lvl[b];
                    newp = m_lvl[b] && m_armed[b];
                end
            end
            m_pend[b] = newp;
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return 32'({main_state, sub_state, op_type, error_code, error_timer});
    endfunction

    function automatic logic [31:0] model_pack();
        logic [5:0] t;
        t = 6'(m_ticks % 64);
        return 32'({m_main, m_sub, m_op, m_err, t});
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check("cycle", dut_pack(), model_pack());
    endtask

    // b: 0 confirm, 1 back, 2 both
    task automatic press(input int b, input int hold);
        if (b != 1) btn_confirm_raw = 1'b1;
        if (b != 0) btn_back_raw = 1'b1;
        repeat (hold) step();
        btn_confirm_raw = 1'b0;
        btn_back_raw = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; btn_confirm_raw = 1'b0; btn_back_raw = 1'b0;
        sw_mode = 3'd0; sw_op = 4'd0; err_req = 1'b0; err_code_in = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", dut_pack(), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // Held confirm with mode 4 enters COMPUTE after sync + debounce + 1.
        sw_mode = 3'd4;
        btn_confirm_raw = 1'b1;
        repeat (5) step();
        check("pre_debounce_main", 32'(main_state), 32'd0);
        repeat (2) step();
        check("enter_main", 32'(main_state), 32'd4);
        check("enter_sub", 32'(sub_state), 32'd0);
        repeat (3) step();
        btn_confirm_raw = 1'b0;
        repeat (10) step();

        // Bounce: toggling every 2 cycles never settles.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn_confirm_raw = ~btn_confirm_raw;
            step();
        end
        btn_confirm_raw = 1'b0;
        repeat (10) step();
        check("bounce_main", 32'(main_state), 32'd4);
        check("bounce_sub", 32'(sub_state), 32'd0);

        press(1, 8);
        check("back_main", 32'(main_state), 32'd0);

        // Invalid mode error, ignored confirm, timed expiry.
        sw_mode = 3'd7;
        press(0, 8);
        check("err_mode", 32'(error_code), 32'd1);
        sw_mode = 3'd1;
        press(0, 8);
        check("err_ignore_main", 32'(main_state), 32'd0);
        check("err_ignore_code", 32'(error_code), 32'd1);
        n = 0;
        while (error_code != 4'd0 && n < 700) begin
            step();
            n++;
        end
        check("err_expire_in_time", 32'(n < 700), 32'd1);
        check("err_clear_cycle", 32'(m_cyc), 32'(TDI * (m_set_cyc / TDI + 64)));

        // Invalid op, back clears, valid op latches.
        sw_mode = 3'd4;
        press(0, 8);
        sw_op = 4'd12;
        press(0, 8);
        check("err_op", 32'(error_code), 32'd2);
        check("err_op_sub", 32'(sub_state), 32'd0);
        press(1, 8);
        check("back_clr_main", 32'(main_state), 32'd0);
        check("back_clr_err", 32'(error_code), 32'd0);
        press(0, 8);
        sw_op = 4'd5;
        press(0, 8);
        check("op_latch", 32'(op_type), 32'd5);
        check("op_sub", 32'(sub_state), 32'd1);

        // Saturation and simultaneous back+confirm.
        press(1, 8);
        sw_mode = 3'd1;
        press(0, 8);
        check("mode1_main", 32'(main_state), 32'd1);
        repeat (17) press(0, 6);
        check("sub_sat", 32'(sub_state), 32'd15);
        press(2, 8);
        check("both_main", 32'(main_state), 32'd0);
        check("both_sub", 32'(sub_state), 32'd0);

        // External error coinciding with an invalid-mode confirm, then async reset.
        sw_mode = 3'd7;
        btn_confirm_raw = 1'b1;
        repeat (6) step();
        err_req = 1'b1;
        err_code_in = 4'd9;
        step();
        err_req = 1'b0;
        err_code_in = 4'd0;
        check("ext_err", 32'(error_code), 32'd9);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 check("async_rst", dut_pack(), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sw_mode = 3'd2;
        repeat (20) step();
        check("held_thru_rst", 32'(main_state), 32'd0);
        btn_confirm_raw = 1'b0;
        repeat (10) step();
        press(0, 8);
        check("repress_main", 32'(main_state), 32'd2);

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_confirm_raw = ~btn_confirm_raw;
            if ($urandom_range(0, 14) == 0) btn_back_raw = ~btn_back_raw;
            if ($urandom_range(0, 9) == 0) sw_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) sw_op = 4'($urandom_range(0, 15));
            err_req = ($urandom_range(0, 59) == 0);
            err_code_in = 4'($urandom_range(0, 15));
            step();
        end
        err_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
